// File: rtl/ollar_pkg.sv
// Shared constants and types for the OLLAR pipeline front end.
// Scoreboard entries carry a fixed-width address so every block agrees on the layout.
package ollar_pkg;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_ADD  = 8'h01,
    OP_SUB  = 8'h02,
    OP_AND  = 8'h03,
    OP_OR   = 8'h04,
    OP_XOR  = 8'h05,
    OP_LD   = 8'h10,
    OP_ST   = 8'h11,
    OP_BR   = 8'h20,
    OP_RTLC = 8'h3F
  } opcode_t;

  // Widest register address a scoreboard entry can hold (up to 256 registers).
  localparam int REG_AW_MAX = 8;

  function automatic int reg_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] addr;
    logic                  late;
  } sb_entry_t;

endpackage

// File: rtl/ollar_operand_fetch_if.sv
// Issue-side handshake between the issue stage and the operand-fetch unit.
interface ollar_operand_fetch_if #(
  parameter int DATA_W   = 32,
  parameter int REG_N    = 32,
  parameter int RD_PORTS = 3
);
  localparam int REG_AW = ollar_pkg::reg_aw(REG_N);

  logic                         issue_valid;
  logic                         issue_ready;
  logic [RD_PORTS*REG_AW-1:0]   src_addr;
  logic                         dst_valid;
  logic [REG_AW-1:0]            dst_addr;
  logic                         dst_late;
  logic [RD_PORTS*DATA_W-1:0]   operand;
  logic                         operand_valid;

  modport master (
    output issue_valid, src_addr, dst_valid, dst_addr, dst_late,
    input  issue_ready, operand, operand_valid
  );

  modport slave (
    input  issue_valid, src_addr, dst_valid, dst_addr, dst_late,
    output issue_ready, operand, operand_valid
  );

endinterface

// File: rtl/ollar_regfile.sv
// Architectural register file: asynchronous read ports, one synchronous write port.
// With ZERO_R0 set, register 0 reads as zero and ignores writes.
module ollar_regfile #(
  parameter int DATA_W   = 32,
  parameter int REG_N    = 32,
  parameter int RD_PORTS = 3,
  parameter int ZERO_R0  = 0,
  localparam int REG_AW  = ollar_pkg::reg_aw(REG_N)
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       we,
  input  logic [REG_AW-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [RD_PORTS*REG_AW-1:0] raddr,
  output logic [RD_PORTS*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [REG_N];

  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (we && !(ZERO_R0 != 0 && waddr == '0)) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [REG_AW-1:0] ra;
    assign ra = raddr[p*REG_AW +: REG_AW];
    assign rdata[p*DATA_W +: DATA_W] = (ZERO_R0 != 0 && ra == '0) ? '0 : mem[ra];
  end

endmodule

// File: rtl/ollar_operand_fetch.sv
// Operand fetch with forwarding: scoreboard of in-flight writes, per-port bypass mux,
// late-result hazard stall and write-back from the retiring slot.
module ollar_operand_fetch
  import ollar_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_N    = 32,
  parameter int DEPTH    = 3,
  parameter int RD_PORTS = 3,
  parameter int ZERO_R0  = 0
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic                    advance,
  input  logic                    flush,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  ollar_operand_fetch_if.slave    bus
);

  localparam int REG_AW = reg_aw(REG_N);

  sb_entry_t                  slot [DEPTH];
  logic [RD_PORTS*DATA_W-1:0] rf_rdata;
  logic [RD_PORTS*DATA_W-1:0] fetch_data;
  logic [RD_PORTS-1:0]        port_hazard;
  logic                       hazard;
  logic                       accept;
  logic                       dst_live;
  logic                       wb_en;

  ollar_regfile #(
    .DATA_W   (DATA_W),
    .REG_N    (REG_N),
    .RD_PORTS (RD_PORTS),
    .ZERO_R0  (ZERO_R0)
  ) u_regfile (
    .clock (clock),
    .Reset (Reset),
    .we    (wb_en),
    .waddr (slot[DEPTH-1].addr[REG_AW-1:0]),
    .wdata (stage_result[(DEPTH-1)*DATA_W +: DATA_W]),
    .raddr (bus.src_addr),
    .rdata (rf_rdata)
  );

  // Scan oldest to youngest so the lowest-index matching slot has the final say.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [REG_AW-1:0] src;
    logic              src_live;
    logic [DATA_W-1:0] value;
    logic              haz;

    assign src      = bus.src_addr[p*REG_AW +: REG_AW];
    assign src_live = !(ZERO_R0 != 0 && src == '0);

    always_comb begin
      value = rf_rdata[p*DATA_W +: DATA_W];
      haz   = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (src_live && slot[k].valid && slot[k].addr == REG_AW_MAX'(src)) begin
          value = stage_result[k*DATA_W +: DATA_W];
          haz   = slot[k].late && (k < DEPTH - 1);
        end
      end
    end

    assign fetch_data[p*DATA_W +: DATA_W] = value;
    assign port_hazard[p]                 = haz;
  end

  assign hazard          = |port_hazard;
  assign bus.issue_ready = advance & ~flush & ~hazard;
  assign accept          = bus.issue_valid & bus.issue_ready;
  assign dst_live        = !(ZERO_R0 != 0 && bus.dst_addr == '0);
  assign wb_en           = ~Reset & ~flush & advance & slot[DEPTH-1].valid;

  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      bus.operand       <= '0;
      bus.operand_valid <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) slot[k].valid <= 1'b0;
      bus.operand_valid <= 1'b0;
    end else if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) slot[k] <= slot[k-1];
      slot[0].valid <= accept & bus.dst_valid & dst_live;
      slot[0].addr  <= REG_AW_MAX'(bus.dst_addr);
      slot[0].late  <= bus.dst_late;
      if (accept) bus.operand <= fetch_data;
      bus.operand_valid <= accept;
    end else begin
      bus.operand_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ollar_operand_fetch.sv
// Randomised scoreboard bench: two DUTs (ZERO_R0 = 0 and 1) share stimulus and are
// checked against an age-based model of in-flight writes and the register file.
module tb_ollar_operand_fetch;
  import ollar_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_N      = 32;
  localparam int DEPTH      = 3;
  localparam int RD_PORTS   = 3;
  localparam int REG_AW     = 5;
  localparam int NUM_CYCLES = 4000;
  localparam int MAXFLY     = 8;
  localparam int OPW        = RD_PORTS * DATA_W;

  logic                       clock = 1'b0;
  logic                       Reset;
  logic                       advance;
  logic                       flush;
  logic [DEPTH*DATA_W-1:0]    stage_result;
  logic                       issue_valid;
  logic [RD_PORTS*REG_AW-1:0] src_addr;
  logic                       dst_valid;
  logic [REG_AW-1:0]          dst_addr;
  logic                       dst_late;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ollar_operand_fetch_if #(.DATA_W(DATA_W), .REG_N(REG_N), .RD_PORTS(RD_PORTS)) bus0 ();
  ollar_operand_fetch_if #(.DATA_W(DATA_W), .REG_N(REG_N), .RD_PORTS(RD_PORTS)) bus1 ();

  assign bus0.issue_valid = issue_valid;
  assign bus0.src_addr    = src_addr;
  assign bus0.dst_valid   = dst_valid;
  assign bus0.dst_addr    = dst_addr;
  assign bus0.dst_late    = dst_late;
  assign bus1.issue_valid = issue_valid;
  assign bus1.src_addr    = src_addr;
  assign bus1.dst_valid   = dst_valid;
  assign bus1.dst_addr    = dst_addr;
  assign bus1.dst_late    = dst_late;

  ollar_operand_fetch #(
    .DATA_W(DATA_W), .REG_N(REG_N), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS), .ZERO_R0(0)
  ) dut0 (
    .clock(clock), .Reset(Reset), .advance(advance), .flush(flush),
    .stage_result(stage_result), .bus(bus0)
  );

  ollar_operand_fetch #(
    .DATA_W(DATA_W), .REG_N(REG_N), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS), .ZERO_R0(1)
  ) dut1 (
    .clock(clock), .Reset(Reset), .advance(advance), .flush(flush),
    .stage_result(stage_result), .bus(bus1)
  );

  // Reference state per instance: register values plus in-flight writes, oldest first,
  // each tagged with how many advancing edges it has seen since issue.
  logic [DATA_W-1:0] mregs   [2][REG_N];
  int                flyDst  [2][MAXFLY];
  bit                flyLate [2][MAXFLY];
  int                flyAge  [2][MAXFLY];
  int                flyN    [2];
  logic [OPW-1:0]    expOp   [2];
  bit                expV    [2];

  typedef struct packed {
    logic [1:0]           v;
    logic [1:0][OPW-1:0]  op;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REG_AW-1:0] pickReg();
    if ($urandom_range(0, 9) == 0) return REG_AW'($urandom_range(0, REG_N - 1));
    return REG_AW'($urandom_range(0, 5));
  endfunction

  function automatic logic [DATA_W-1:0] stageVal(input int a);
    return stage_result[a*DATA_W +: DATA_W];
  endfunction

  function automatic int youngest(input int z, input int r);
    for (int i = flyN[z] - 1; i >= 0; i--)
      if (flyDst[z][i] == r) return i;
    return -1;
  endfunction

  task automatic modelStep();
    exp_t e;
    for (int z = 0; z < 2; z++) begin
      logic [OPW-1:0] ops;
      bit haz, rdy, acc, actRdy;
      haz = 0;
      ops = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
        int r, i;
        r = int'(src_addr[p*REG_AW +: REG_AW]);
        i = youngest(z, r);
        if (z == 1 && r == 0) ops[p*DATA_W +: DATA_W] = '0;
        else if (i >= 0) begin
          ops[p*DATA_W +: DATA_W] = stageVal(flyAge[z][i]);
          if (flyLate[z][i] && flyAge[z][i] < DEPTH - 1) haz = 1;
        end else ops[p*DATA_W +: DATA_W] = mregs[z][r];
      end
      rdy    = advance && !flush && !haz;
      acc    = issue_valid && rdy;
      actRdy = (z == 0) ? bus0.issue_ready : bus1.issue_ready;
      checkOutput((z == 0) ? "issue_ready0" : "issue_ready1", OPW'(actRdy), OPW'(rdy));

      if (Reset) begin
        for (int r = 0; r < REG_N; r++) mregs[z][r] = '0;
        flyN[z]  = 0;
        expOp[z] = '0;
        expV[z]  = 0;
      end else if (flush) begin
        flyN[z] = 0;
        expV[z] = 0;
      end else if (advance) begin
        if (flyN[z] > 0 && flyAge[z][0] == DEPTH - 1) begin
          mregs[z][flyDst[z][0]] = stageVal(DEPTH - 1);
          for (int i = 1; i < flyN[z]; i++) begin
            flyDst[z][i-1]  = flyDst[z][i];
            flyLate[z][i-1] = flyLate[z][i];
            flyAge[z][i-1]  = flyAge[z][i];
          end
          flyN[z]--;
        end
        for (int i = 0; i < flyN[z]; i++) flyAge[z][i]++;
        if (acc && dst_valid && !(z == 1 && dst_addr == '0)) begin
          flyDst[z][flyN[z]]  = int'(dst_addr);
          flyLate[z][flyN[z]] = dst_late;
          flyAge[z][flyN[z]]  = 0;
          flyN[z]++;
        end
        expV[z] = acc;
        if (acc) expOp[z] = ops;
      end else begin
        expV[z] = 0;
      end
      e.v[z]  = expV[z];
      e.op[z] = expOp[z];
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit forceReset);
    @(negedge clock);
    Reset       = forceReset || ($urandom_range(0, 149) == 0);
    advance     = ($urandom_range(0, 9) != 0);
    flush       = ($urandom_range(0, 29) == 0);
    issue_valid = ($urandom_range(0, 9) < 7);
    for (int p = 0; p < RD_PORTS; p++) src_addr[p*REG_AW +: REG_AW] = pickReg();
    dst_valid = ($urandom_range(0, 9) < 8);
    dst_addr  = pickReg();
    dst_late  = ($urandom_range(0, 9) < 3);
    for (int k = 0; k < DEPTH; k++) stage_result[k*DATA_W +: DATA_W] = $urandom;
    #1;
    modelStep();
  endtask

  // Monitor: one expected entry per edge, covering both valid pulse and held operands.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("operand_valid0", OPW'(bus0.operand_valid), OPW'(e.v[0]));
        checkOutput("operand_valid1", OPW'(bus1.operand_valid), OPW'(e.v[1]));
        checkOutput("operand0", bus0.operand, e.op[0]);
        checkOutput("operand1", bus1.operand, e.op[1]);
      end
    end
  end

  initial begin
    Reset        = 1'b1;
    advance      = 1'b0;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    src_addr     = '0;
    dst_valid    = 1'b0;
    dst_addr     = '0;
    dst_late     = 1'b0;
    stage_result = '0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    for (int c = 0; c < NUM_CYCLES; c++) applyStimulus(1'b0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("scoreboard_drained", OPW'(sb.size()), OPW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ollar_operand_fetch.md
# ollar_operand_fetch

Parametrised operand-fetch and forwarding unit for the OLLAR pipeline. It holds the architectural register file and a scoreboard of in-flight destination writes, one slot per downstream pipeline stage. It returns up to RD_PORTS operands per issued instruction, bypassing from the youngest matching stage. It stalls issue only when the needed result is produced late (load-type) and is not yet available, and it performs write-back when an entry retires from the last slot.

## Interface
- DATA_W, 32, register/operand width
- REG_N, 32, number of architectural registers; REG_AW = clog2(REG_N)
- DEPTH, 3, in-flight stages tracked (slot 0 = youngest, DEPTH-1 = retiring); DEPTH ≥ 1
- RD_PORTS, 3, source operands per instruction
- ZERO_R0, 0, 1 = register 0 reads as zero and is never written, tracked or forwarded

Ports:
- clock  in  1  clock
- Reset  in  1  synchronous, active-high; clock clock
- advance  in  1  pipeline moves this cycle; 0 = scoreboard and outputs hold
- flush  in  1  kill all in-flight entries without write-back
- issue_valid  in  1  instruction presented
- issue_ready  out  1  instruction accepted this cycle (combinational)
- src_addr  in  RD_PORTS*REG_AW  source register numbers, port p at [p*REG_AW +: REG_AW]
- dst_valid  in  1  instruction writes a register
- dst_addr  in  REG_AW  destination register
- dst_late  in  1  result valid only at slot DEPTH-1 (LD-type)
- stage_result  in  DEPTH*DATA_W  result currently in stage k, at [k*DATA_W +: DATA_W]
- operand  out  RD_PORTS*DATA_W  registered operands
- operand_valid  out  1  one-cycle pulse: operand holds an accepted instruction's sources

## Operation
- Slot k = {valid, addr, late}. Slot k matches source s if valid && addr == s (and s != 0 when ZERO_R0).
- Per port, the lookup priority is slot 0, then 1, ..., then DEPTH-1, then the register file. The lowest-index matching slot alone decides the result.
- Hazard: any port whose lowest-index match is at slot k < DEPTH-1 with late = 1.
- issue_ready = advance & ~flush & ~hazard. issue_ready is independent of issue_valid.
- accept = issue_valid & issue_ready.
- On accept, operand[p] is loaded with stage_result[k] of the matching slot, or with R[src] if no slot matches. operand_valid is set to 1; otherwise operand_valid is set to 0 and operand holds.
- When advance = 1, these updates occur together:
  - slot[k] ← slot[k-1] for k ≥ 1.
  - slot[0] ← {accept & dst_valid & ~(ZERO_R0 & dst_addr == 0), dst_addr, dst_late}.
  - If the old slot[DEPTH-1] is valid, R[addr] ← stage_result[DEPTH-1].
- Same-edge retire and read of the same register: the reader takes the value from the slot[DEPTH-1] bypass, so it is never stale.
- When advance = 0: slots, register file and operand hold; operand_valid = 0.
- flush (when not in Reset) clears all slot valid bits, suppresses the retiring write-back and clears operand_valid. Register file contents are unchanged.
- Priority: Reset > flush > advance.
- Reset: all slot valid = 0, every R = 0, operand = 0, operand_valid = 0.

## Timing
- Operand latency: 1 cycle from the accepting edge.
- A dependent instruction issued the cycle after its producer gets operands forwarded with 0 stall cycles (non-late producer).
- A late producer followed immediately by a consumer stalls the consumer DEPTH-1 cycles (2 at defaults). Stalled cycles require advance = 1 to age the producer.
- Write-back is visible through the register file DEPTH advancing cycles after issue; before that it is covered by the bypass.
- Reset or flush asserted mid-stall: hazard clears the next cycle.

## Structure
- Shared package ollar_pkg:
  - opcode constants (NOP … RTLC, 8-bit)
  - typedef sb_entry_t {valid, addr[REG_AW], late}
  - REG_AW derivation
- Sub-module ollar_regfile: REG_N×DATA_W, RD_PORTS asynchronous read ports, one synchronous write port, synchronous Reset to zero, ZERO_R0 honoured.
- Top level: scoreboard shift register, per-port priority mux and hazard logic, output registers.

## Test plan
All scenarios use defaults (DATA_W = 32, DEPTH = 3, RD_PORTS = 3, advance = 1).
- Back-to-back forward: issue dst R5 (non-late); next cycle issue src0 = R5 with stage_result[0] = 0x1234 → no stall, operand[0] = 0x1234, operand_valid = 1.
- Late hazard: issue dst R7 dst_late = 1; next cycle issue src1 = R7 → issue_ready = 0 for 2 cycles; on the third cycle it is accepted with operand[1] = stage_result[2] = 0xDEAD_BEEF.
- Retire: issue dst R3, then 3 cycles with stage_result[2] = 0x55 at the retiring cycle → a later read of R3 with no matching slot returns 0x55.
- Priority: R4 in slots 0 and 2 with results 0xA and 0xB → operand = 0xA.
- Flush: R9 in slot 2, flush = 1 → R9 stays 0, all slots empty, the following issue is accepted with no stall.
- Reset mid-stall and ZERO_R0 = 1:
  - Reset during a late-hazard stall → next cycle issue_ready = 1, operand_valid = 0.
  - With ZERO_R0 = 1, issue dst R0 late then src R0 → no stall, operand = 0.
